nios_fprint_sysid_arbiter: RTL and testbench
============================================

# nios_fprint_sysid_arbiter

Round-robin arbiter that shares the single system-ID control slave among NUM_REQ Nios cores in the fingerprinting system. Each core gets its own Avalon-MM read-only slave port with waitrequest and readdatavalid. The arbiter sequences one read at a time into the combinational sys-id slave and registers the returned word. It also checks every ID-word read against an expected value and raises a sticky mismatch flag.

## Interface
- NUM_REQ, 4: number of requester ports, 2..8.
- EXPECTED_ID, 32'h0000_0000: value the ID word (address 0) must return.
- clock  in  1  single system clock; all logic rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_read  in  NUM_REQ  per-requester read strobe.
- req_address  in  NUM_REQ  per-requester word address. Bit i belongs to requester i; 0 = ID, 1 = timestamp.
- req_waitrequest  out  NUM_REQ  high = command not accepted this cycle.
- req_readdata  out  32*NUM_REQ  slice [32i+31:32i] belongs to requester i.
- req_readdatavalid  out  NUM_REQ  one-cycle pulse carrying response data.
- sid_address  out  1  address driven to the sys-id slave.
- sid_readdata  in  32  combinational return from the sys-id slave.
- id_mismatch  out  1  sticky; set when an ID read differs from EXPECTED_ID.

## Operation
- FSM states: IDLE, RESP.
- IDLE, no req_read asserted: stay in IDLE. All waitrequest high, sid_address = 0.
- IDLE, any req_read asserted:
  - Winner = first requesting index found scanning from (last_grant+1) mod NUM_REQ upward with wrap.
  - sid_address = req_address[winner]; req_waitrequest[winner] = 0, all others 1.
  - Latch sid_readdata into data_q, winner into grant_q, last_grant <= winner.
  - Go to RESP.
- RESP:
  - req_readdatavalid[grant_q] = 1. req_readdata slice grant_q = data_q; other slices hold their last value.
  - All waitrequest high. Return to IDLE unconditionally.
- A requester whose read is not accepted holds read and address stable until waitrequest drops (Avalon rule); the arbiter never drops a pending request.
- Mismatch check: on acceptance with sid_address = 0, if sid_readdata != EXPECTED_ID then set id_mismatch. It clears only on reset.
- last_grant resets to NUM_REQ-1, so requester 0 has first priority after reset.

## Timing
- Reset values: waitrequest all 1, readdatavalid all 0, readdata all 0, sid_address 0, id_mismatch 0, state IDLE, data_q 0.
- Latency: command accepted in cycle N; readdatavalid in cycle N+1. Exactly one response per accepted read.
- Throughput: at most one read per 2 cycles. The earliest next acceptance is N+2.
- Fairness: with all NUM_REQ requesting continuously, each is served once every 2*NUM_REQ cycles. Worst-case wait is 2*NUM_REQ-1 cycles after assert.
- Simultaneous requests: only the rotating-priority winner is accepted; the others see waitrequest = 1.
- A request that arrives while in RESP is considered in the following IDLE cycle.
- Reset mid-operation: an asynchronous reset_n low in RESP aborts the response. No readdatavalid is emitted and the state returns to IDLE.
- Reset deassertion is synchronised externally; the block assumes a clean release.
- No combinational path from req_read to req_readdatavalid. The path from req_read/req_address to sid_address and waitrequest is combinational (single level of arbitration logic).

## Structure
- Shared package nios_fprint_sysid_pkg:
  - state enum (IDLE, RESP);
  - SID_ADDR_ID = 1'b0 and SID_ADDR_TS = 1'b1;
  - MAX_REQ = 8.
- One natural sub-module: nios_fprint_rr_pick, a combinational rotating-priority picker. Inputs: request vector and last_grant. Outputs: winner index and any_req. Reusable by other shared-slave arbiters.
- The top holds the FSM, registers and mismatch logic. Expected size is about 150–250 lines.

## Test plan
- Reset then idle: reset_n low 3 cycles, release, no reads → waitrequest = 4'b1111, readdatavalid = 0, id_mismatch = 0 for 20 cycles.
- Single read: sys-id model returns 32'h0000_0000 at address 0 and 32'h5A5A_0001 at address 1. Requester 2 reads address 1 → waitrequest[2] low in the accept cycle; next cycle readdatavalid = 4'b0100 and slice 2 = 32'h5A5A_0001.
- Contention: all 4 requesters assert reads in the same cycle and hold until served → acceptance order 0,1,2,3 on cycles 0,2,4,6; each gets exactly one readdatavalid.
- Rotation after partial use: requester 1 is served, then requesters 0 and 1 both request → 0 is served before 1.
- Mismatch: EXPECTED_ID = 32'h1234_5678 and the model returns 32'h0 on address 0 → id_mismatch rises the cycle after acceptance and stays high through later matching reads until reset.
- Reset mid-RESP: assert reset_n low during the RESP cycle → no readdatavalid pulse, all outputs at reset values, and the next read after release completes normally.

Source files
------------

// File: rtl/nios_fprint_sysid_pkg.sv
// Shared types and constants for the fingerprint sys-id slave arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package nios_fprint_sysid_pkg;

    // Arbiter FSM: IDLE accepts at most one command, RESP returns its data.
    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    // Word addresses decoded by the sys-id slave.
    localparam logic SID_ADDR_ID = 1'b0;
    localparam logic SID_ADDR_TS = 1'b1;

    // Largest requester count the picker and arbiter are sized for.
    localparam int MAX_REQ = 8;

endpackage

// File: rtl/nios_fprint_rr_pick.sv
// Combinational rotating-priority picker for shared-slave arbiters.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; the caller decides when the winner is consumed.
//
// Ports:
//   req        request vector, bit i = requester i
//   last_grant index served most recently; search starts one above it
//   winner     first requesting index at or after last_grant+1, with wrap
//   any_req    high when at least one request bit is set
module nios_fprint_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [IDX_W-1:0]   winner,
    output logic               any_req
);

    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] idx;

    // Walk offsets from farthest to nearest so the nearest requester
    // after last_grant is the final assignment and wins.
    always_comb begin
        winner  = last_grant;
        any_req = |req;
        sum     = '0;
        idx     = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            sum = {1'b0, last_grant} + (IDX_W+1)'(k);
            if (sum >= (IDX_W+1)'(NUM_REQ)) begin
                sum = sum - (IDX_W+1)'(NUM_REQ);
            end
            idx = sum[IDX_W-1:0];
            if (req[idx]) begin
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/nios_fprint_sysid_arbiter.sv
// Round-robin arbiter sharing one combinational sys-id slave among NUM_REQ cores.
// Latency: command accepted in cycle N, readdatavalid pulse in cycle N+1.
// Backpressure: waitrequest high except for the winner in IDLE; one read per 2 cycles.
//
// Ports:
//   clock, reset_n     system clock, asynchronous active-low reset
//   req_read/address   per-requester Avalon-MM read command (address 0=ID, 1=timestamp)
//   req_waitrequest    low only for the requester accepted this cycle
//   req_readdata       32-bit slice per requester, holds its last returned word
//   req_readdatavalid  one-cycle pulse on the requester being answered
//   sid_address        address presented to the sys-id slave
//   sid_readdata       combinational return from the sys-id slave
//   id_mismatch        sticky; an ID-word read returned something other than EXPECTED_ID
module nios_fprint_sysid_arbiter
    import nios_fprint_sysid_pkg::*;
#(
    parameter int          NUM_REQ     = 4,
    parameter logic [31:0] EXPECTED_ID = 32'h0000_0000
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [NUM_REQ-1:0]     req_read,
    input  logic [NUM_REQ-1:0]     req_address,
    output logic [NUM_REQ-1:0]     req_waitrequest,
    output logic [32*NUM_REQ-1:0]  req_readdata,
    output logic [NUM_REQ-1:0]     req_readdatavalid,
    output logic                   sid_address,
    input  logic [31:0]            sid_readdata,
    output logic                   id_mismatch
);

    localparam int IDX_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > MAX_REQ) begin : g_bad_num_req
        $error("nios_fprint_sysid_arbiter: NUM_REQ must be 2..MAX_REQ");
    end

    state_t           state_q, state_d;
    logic [IDX_W-1:0] last_grant_q;
    logic [IDX_W-1:0] grant_q;
    logic [IDX_W-1:0] winner;
    logic             any_req;
    logic             accept;
    logic [31:0]      data_q;
    logic [31:0]      hold_q [NUM_REQ];

    nios_fprint_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req        (req_read),
        .last_grant (last_grant_q),
        .winner     (winner),
        .any_req    (any_req)
    );

    // Next state and command-side outputs. The slave is combinational, so
    // the winner's address goes straight out and the data is captured on
    // the same edge that accepts the command.
    always_comb begin
        state_d         = state_q;
        req_waitrequest = '1;
        sid_address     = SID_ADDR_ID;
        accept          = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    sid_address             = req_address[winner];
                    req_waitrequest[winner] = 1'b0;
                    accept                  = 1'b1;
                    state_d                 = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Valid is decoded from registered state only, so req_read never
    // reaches req_readdatavalid combinationally.
    always_comb begin
        req_readdatavalid = '0;
        if (state_q == RESP) begin
            req_readdatavalid[grant_q] = 1'b1;
        end
    end

    // The answered slice shows data_q during RESP; it is copied into the
    // per-requester hold register at the end of RESP so it persists. A
    // reset during RESP therefore never commits the aborted word.
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_rdata
        assign req_readdata[32*i +: 32] =
            (state_q == RESP && grant_q == IDX_W'(i)) ? data_q : hold_q[i];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            last_grant_q <= IDX_W'(NUM_REQ - 1);
            grant_q      <= '0;
            data_q       <= '0;
            id_mismatch  <= 1'b0;
            for (int i = 0; i < NUM_REQ; i++) begin
                hold_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            if (accept) begin
                data_q       <= sid_readdata;
                grant_q      <= winner;
                last_grant_q <= winner;
                if (sid_address == SID_ADDR_ID && sid_readdata != EXPECTED_ID) begin
                    id_mismatch <= 1'b1;
                end
            end
            if (state_q == RESP) begin
                hold_q[grant_q] <= data_q;
            end
        end
    end

endmodule

// File: tb/tb_nios_fprint_sysid_arbiter.sv
// Self-checking bench for nios_fprint_sysid_arbiter (NUM_REQ = 4).
// Inputs are driven 1 time unit after the rising edge, outputs sampled on the falling edge.
// Directed vectors, hand sequences for multi-cycle corners, then a randomized model run.
module tb_nios_fprint_sysid_arbiter;

    localparam int          N      = 4;
    localparam logic [31:0] EXP_ID = 32'h1234_5678;
    localparam logic [31:0] TS_W   = 32'h5A5A_0001;

    logic          clock;
    logic          reset_n;
    logic [N-1:0]  req_read;
    logic [N-1:0]  req_address;
    logic [N-1:0]  req_waitrequest;
    logic [32*N-1:0] req_readdata;
    logic [N-1:0]  req_readdatavalid;
    logic          sid_address;
    logic [31:0]   sid_readdata;
    logic          id_mismatch;

    logic [31:0]   id_val;
    logic [31:0]   ts_val;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural sys-id slave: ID word at address 0, timestamp at address 1.
    assign sid_readdata = sid_address ? ts_val : id_val;

    nios_fprint_sysid_arbiter #(
        .NUM_REQ     (N),
        .EXPECTED_ID (EXP_ID)
    ) dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .req_read          (req_read),
        .req_address       (req_address),
        .req_waitrequest   (req_waitrequest),
        .req_readdata      (req_readdata),
        .req_readdatavalid (req_readdatavalid),
        .sid_address       (sid_address),
        .sid_readdata      (sid_readdata),
        .id_mismatch       (id_mismatch)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic reset_dut();
        reset_n     = 1'b0;
        req_read    = '0;
        req_address = '0;
        repeat (3) tick();
        reset_n = 1'b1;
    endtask

    typedef struct {
        logic [3:0]  rd;
        logic [3:0]  addr;
        logic [3:0]  exp_wait;
        logic        exp_sid;
        logic [3:0]  exp_rdv;
        int          exp_idx;
        logic [31:0] exp_data;
    } vec_t;

    vec_t tbl [8];

    // Contention bookkeeping
    int acc_q [$];
    int cyc_q [$];
    int rdv_cnt [N];
    logic [3:0] pend;
    logic [3:0] paddr;

    // Reference model state for the random run
    int          m_lg;
    bit          m_busy;
    int          m_resp;
    bit          m_mm;
    logic [31:0] m_data [N];

    initial begin
        id_val = EXP_ID;
        ts_val = TS_W;

        // Arbitration walk starting from last_grant = 3 after reset.
        tbl[0] = '{4'b0001, 4'b0000, 4'b1110, 1'b0, 4'b0001, 0,  EXP_ID};
        tbl[1] = '{4'b1111, 4'b0010, 4'b1101, 1'b1, 4'b0010, 1,  TS_W};
        tbl[2] = '{4'b0011, 4'b0000, 4'b1110, 1'b0, 4'b0001, 0,  EXP_ID};
        tbl[3] = '{4'b1000, 4'b1000, 4'b0111, 1'b1, 4'b1000, 3,  TS_W};
        tbl[4] = '{4'b1001, 4'b0001, 4'b1110, 1'b1, 4'b0001, 0,  TS_W};
        tbl[5] = '{4'b0110, 4'b0100, 4'b1101, 1'b0, 4'b0010, 1,  EXP_ID};
        tbl[6] = '{4'b0100, 4'b0100, 4'b1011, 1'b1, 4'b0100, 2,  TS_W};
        tbl[7] = '{4'b0000, 4'b0000, 4'b1111, 1'b0, 4'b0000, -1, 32'h0};

        // ---------------- reset, then idle ----------------
        reset_n     = 1'b0;
        req_read    = '0;
        req_address = '0;
        @(negedge clock);
        chk("rst_wait",  128'(req_waitrequest),   128'(4'b1111));
        chk("rst_rdv",   128'(req_readdatavalid), 128'(4'b0000));
        chk("rst_rdata", 128'(req_readdata),      128'(0));
        chk("rst_sid",   128'(sid_address),       128'(1'b0));
        chk("rst_mm",    128'(id_mismatch),       128'(1'b0));
        repeat (3) tick();
        reset_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            chk("idle", 128'({req_waitrequest, req_readdatavalid, id_mismatch}),
                128'({4'b1111, 4'b0000, 1'b0}));
        end
        tick();

        // ---------------- table-driven vectors ----------------
        reset_dut();
        for (int t = 0; t < 8; t++) begin
            req_read    = tbl[t].rd;
            req_address = tbl[t].addr;
            @(negedge clock);
            chk("tbl_wait", 128'(req_waitrequest), 128'(tbl[t].exp_wait));
            chk("tbl_sid",  128'(sid_address),     128'(tbl[t].exp_sid));
            tick();
            req_read = '0;
            @(negedge clock);
            chk("tbl_rdv", 128'(req_readdatavalid), 128'(tbl[t].exp_rdv));
            if (tbl[t].exp_idx >= 0) begin
                chk("tbl_data", 128'(32'(req_readdata >> (32 * tbl[t].exp_idx))),
                    128'(tbl[t].exp_data));
            end
            tick();
        end
        chk("tbl_mm", 128'(id_mismatch), 128'(1'b0));

        // ---------------- contention: all four hold until served ----------------
        reset_dut();
        pend = 4'b1111;
        for (int i = 0; i < N; i++) rdv_cnt[i] = 0;
        for (int c = 0; c < 12; c++) begin
            logic [3:0] acc;
            req_read    = pend;
            req_address = 4'b0101;
            @(negedge clock);
            acc = ~req_waitrequest & req_read;
            for (int i = 0; i < N; i++) begin
                if (((acc >> i) & 4'b1) != 4'b0) begin
                    acc_q.push_back(i);
                    cyc_q.push_back(c);
                end
                if (((req_readdatavalid >> i) & 4'b1) != 4'b0) rdv_cnt[i]++;
            end
            pend = pend & ~acc;
            tick();
        end
        req_read = '0;
        chk("cont_count", 128'(acc_q.size()), 128'(4));
        for (int k = 0; k < acc_q.size(); k++) begin
            chk("cont_order", 128'(acc_q[k]), 128'(k));
            chk("cont_cycle", 128'(cyc_q[k]), 128'(2 * k));
        end
        for (int i = 0; i < N; i++) chk("cont_rdv_once", 128'(rdv_cnt[i]), 128'(1));

        // ---------------- sticky ID mismatch ----------------
        id_val      = 32'h0;
        req_read    = 4'b0001;
        req_address = 4'b0000;
        @(negedge clock);
        chk("mm_accept_wait", 128'(req_waitrequest), 128'(4'b1110));
        chk("mm_before",      128'(id_mismatch),     128'(1'b0));
        tick();
        req_read = '0;
        id_val   = EXP_ID;
        @(negedge clock);
        chk("mm_rises", 128'(id_mismatch), 128'(1'b1));
        tick();
        for (int r = 0; r < 3; r++) begin
            req_read    = 4'b0010;
            req_address = 4'b0000;
            tick();
            req_read = '0;
            tick();
        end
        @(negedge clock);
        chk("mm_sticky", 128'(id_mismatch), 128'(1'b1));
        tick();
        reset_dut();
        @(negedge clock);
        chk("mm_cleared", 128'(id_mismatch), 128'(1'b0));
        tick();

        // ---------------- reset during RESP ----------------
        req_read    = 4'b0010;
        req_address = 4'b0010;
        @(negedge clock);
        chk("mr_accept", 128'(req_waitrequest), 128'(4'b1101));
        tick();
        reset_n  = 1'b0;
        req_read = '0;
        @(negedge clock);
        chk("mr_rdv",   128'(req_readdatavalid), 128'(4'b0000));
        chk("mr_wait",  128'(req_waitrequest),   128'(4'b1111));
        chk("mr_rdata", 128'(req_readdata),      128'(0));
        chk("mr_sid",   128'(sid_address),       128'(1'b0));
        tick();
        tick();
        reset_n = 1'b1;
        @(negedge clock);
        chk("mr_no_late_rdv", 128'(req_readdatavalid), 128'(4'b0000));
        tick();
        req_read    = 4'b0010;
        req_address = 4'b0010;
        @(negedge clock);
        chk("mr_next_accept", 128'(req_waitrequest), 128'(4'b1101));
        tick();
        req_read = '0;
        @(negedge clock);
        chk("mr_next_rdv",  128'(req_readdatavalid), 128'(4'b0010));
        chk("mr_next_data", 128'(req_readdata[63:32]), 128'(TS_W));
        tick();

        // ---------------- randomized run against a reference model ----------------
        reset_dut();
        pend   = '0;
        paddr  = '0;
        m_lg   = N - 1;
        m_busy = 1'b0;
        m_resp = -1;
        m_mm   = 1'b0;
        for (int i = 0; i < N; i++) m_data[i] = '0;
        for (int c = 0; c < 2500; c++) begin
            int          acc;
            logic [3:0]  e_wait;
            logic        e_sid;
            logic [3:0]  e_rdv;
            logic [127:0] e_rd;
            logic [31:0] d;
            // Avalon requesters: a new command is held until it is accepted.
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(2) == 0) begin
                    pend[i]  = 1'b1;
                    paddr[i] = 1'($urandom_range(1));
                end
            end
            ts_val      = $urandom;
            id_val      = ($urandom_range(400) == 0) ? $urandom : EXP_ID;
            req_read    = pend;
            req_address = paddr;

            // Winner: first pending requester after the last one served,
            // unless the previous cycle accepted (one read per two cycles).
            acc = -1;
            if (!m_busy) begin
                for (int k = 1; k <= N; k++) begin
                    int idx;
                    idx = (m_lg + k) % N;
                    if (acc < 0 && pend[idx[1:0]]) acc = idx;
                end
            end
            e_wait = 4'b1111;
            e_sid  = 1'b0;
            if (acc >= 0) begin
                e_wait = ~(4'b0001 << acc);
                e_sid  = paddr[acc[1:0]];
            end
            e_rdv = (m_resp >= 0) ? (4'b0001 << m_resp) : 4'b0000;
            for (int i = 0; i < N; i++) e_rd[32*i +: 32] = m_data[i];

            @(negedge clock);
            chk("rnd_wait",  128'(req_waitrequest),   128'(e_wait));
            chk("rnd_sid",   128'(sid_address),       128'(e_sid));
            chk("rnd_rdv",   128'(req_readdatavalid), 128'(e_rdv));
            chk("rnd_rdata", req_readdata,            e_rd);
            chk("rnd_mm",    128'(id_mismatch),       128'(m_mm));

            m_resp = acc;
            m_busy = (acc >= 0);
            if (acc >= 0) begin
                d = paddr[acc[1:0]] ? ts_val : id_val;
                m_data[acc[1:0]] = d;
                if (!paddr[acc[1:0]] && d != EXP_ID) m_mm = 1'b1;
                pend[acc[1:0]] = 1'b0;
                m_lg = acc;
            end
            tick();
        end
        req_read = '0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
